// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak input gather path.
package keccak_pkg;

    localparam int KECCAK_WORDS = 16;
    localparam int KECCAK_BLKW  = 512;
    localparam int KECCAK_IDXW  = 4;

    localparam logic [KECCAK_WORDS-1:0] MASK_FULL = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/keccak_gather_wreg.sv
// One 32-bit word slot of the gather block: data register plus its "written" flag.
module keccak_gather_wreg
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic        clr_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o,
    output logic        set_o
);

    logic [31:0] word_q;
    logic        set_q;

    // Data survives the flag clear so a handed-off block stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            set_q  <= 1'b0;
        end else begin
            if (we_i) begin
                word_q <= d_i;
            end
            if (clr_i) begin
                set_q <= 1'b0;
            end else if (we_i) begin
                set_q <= 1'b1;
            end
        end
    end

    assign q_o   = word_q;
    assign set_o = set_q;

endmodule

// File: rtl/keccak_gather.sv
// Packs sixteen CPU-written 32-bit words into a 512-bit block offered via valid/ready.
// Optional build macro KECCAK_GATHER_ZPAD_EN: accept partial blocks, unwritten words read as zero.
module keccak_gather
    import keccak_pkg::*;
#(
    parameter int NWORDS = KECCAK_WORDS,
    parameter int IDXW   = KECCAK_IDXW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [5:0]            num,
    input  logic [31:0]           in32,
    input  logic                  start,
    output logic [NWORDS*32-1:0]  out512,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NWORDS-1:0]     word_mask,
    output logic                  busy,
    output logic                  err
);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [IDXW-1:0]   widx;
    logic [NWORDS-1:0] mask, we_vec, mask_nxt;
    logic              wr_ok, start_ok, hs;
    logic              unused_num;

    assign widx       = num[IDXW-1:0];
    assign unused_num = ^num[5:IDXW];

    // The start check sees the mask including a same-cycle write.
    always_comb begin
        wr_ok  = en && (state_q != ST_HOLD);
        we_vec = '0;
        if (wr_ok) begin
            we_vec[widx] = 1'b1;
        end
        mask_nxt = mask | we_vec;
`ifdef KECCAK_GATHER_ZPAD_EN
        start_ok = (mask_nxt != '0);
`else
        start_ok = (mask_nxt == MASK_FULL);
`endif
        hs = (state_q == ST_HOLD) && out_ready;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (start && start_ok) begin
                    state_d = ST_HOLD;
                end else begin
                    err_d = start;
                    if (mask_nxt != '0) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_HOLD: begin
                err_d = en;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        logic [31:0] q;
        logic        set;

        keccak_gather_wreg u_wreg (
            .clk   (clk),
            .rst_n (rst_n),
            .we_i  (we_vec[k]),
            .clr_i (hs),
            .d_i   (in32),
            .q_o   (q),
            .set_o (set)
        );

        assign mask[k] = set;
`ifdef KECCAK_GATHER_ZPAD_EN
        assign out512[32*k +: 32] = ((state_q == ST_HOLD) && !set) ? 32'h0 : q;
`else
        assign out512[32*k +: 32] = q;
`endif
    end

    assign word_mask = mask;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_HOLD);
    assign err       = err_q;

endmodule

// File: tb/tb_keccak_gather.sv
// Bench for keccak_gather: directed literal checks plus randomized traffic against a word-array model.
module tb_keccak_gather;

`ifdef KECCAK_GATHER_ZPAD_EN
    localparam bit ZPAD = 1'b1;
`else
    localparam bit ZPAD = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [5:0]   num;
    logic [31:0]  in32;
    logic         start;
    logic [511:0] out512;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  word_mask;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_words [16];
    logic [15:0] m_mask;
    logic        m_hold;
    logic        m_err;

    keccak_gather dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .num       (num),
        .in32      (in32),
        .start     (start),
        .out512    (out512),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_mask (word_mask),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] model_block();
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            b[32*k +: 32] = (ZPAD && m_hold && !m_mask[k]) ? 32'h0 : m_words[k];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_words[k] = 32'h0;
        m_mask = '0;
        m_hold = 1'b0;
        m_err  = 1'b0;
    endtask

    // Applies one clock edge worth of spec rules to the model, using the inputs held across the edge.
    task automatic model_step();
        m_err = 1'b0;
        if (m_hold) begin
            if (en) m_err = 1'b1;
            if (out_ready) begin
                m_hold = 1'b0;
                m_mask = '0;
            end
        end else begin
            if (en) begin
                m_words[num[3:0]] = in32;
                m_mask[num[3:0]]  = 1'b1;
            end
            if (start) begin
                if (m_mask == 16'hFFFF || (ZPAD && m_mask != 16'h0)) m_hold = 1'b1;
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic e, input logic [5:0] n, input logic [31:0] d,
                       input logic s, input logic r);
        en = e; num = n; in32 = d; start = s; out_ready = r;
        @(posedge clk);
        model_step();
        #1;
        en = 1'b0; start = 1'b0; out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("cmp_out512", out512, model_block());
        chk("cmp_valid", 512'(out_valid), 512'(m_hold));
        chk("cmp_busy", 512'(busy), 512'(m_hold));
        chk("cmp_mask", 512'(word_mask), 512'(m_mask));
        chk("cmp_err", 512'(err), 512'(m_err));
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; num = '0; in32 = '0; start = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cyc(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
        chk("rst_valid", 512'(out_valid), 512'(1'b0));
        chk("rst_mask", 512'(word_mask), 512'(16'h0));
        chk("rst_out512", out512, 512'h0);
        chk("rst_err", 512'(err), 512'(1'b0));

        // Full block, consumer stalls three cycles.
        for (int k = 0; k < 16; k++) cyc(1'b1, 6'(k), 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
        chk("full_valid", 512'(out_valid), 512'(1'b1));
        chk("full_busy", 512'(busy), 512'(1'b1));
        repeat (3) begin
            cyc(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
            chk("stall_valid", 512'(out_valid), 512'(1'b1));
        end
        chk("full_w0", 512'(out512[31:0]), 512'(32'h1000_0000));
        chk("full_w15", 512'(out512[511:480]), 512'(32'h1000_000F));
        cyc(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        chk("hs_valid", 512'(out_valid), 512'(1'b0));
        chk("hs_mask", 512'(word_mask), 512'(16'h0));
        chk("hs_keep_w0", 512'(out512[31:0]), 512'(32'h1000_0000));

        // Fifteen words, index 7 missing.
        for (int k = 0; k < 16; k++)
            if (k != 7) cyc(1'b1, 6'(k), 32'h2000_0000 + 32'(k), 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
`ifdef KECCAK_GATHER_ZPAD_EN
        chk("zp_valid", 512'(out_valid), 512'(1'b1));
        chk("zp_w7", 512'(out512[255:224]), 512'(32'h0));
        chk("zp_w8", 512'(out512[287:256]), 512'(32'h2000_0008));
        chk("zp_err", 512'(err), 512'(1'b0));
        cyc(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            if (k != 7) cyc(1'b1, 6'(k), 32'h2000_0000 + 32'(k), 1'b0, 1'b0);
`else
        chk("part_err", 512'(err), 512'(1'b1));
        chk("part_valid", 512'(out_valid), 512'(1'b0));
        chk("part_mask", 512'(word_mask), 512'(16'hFF7F));
        cyc(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
        chk("part_err_drop", 512'(err), 512'(1'b0));
`endif

        // Last word together with start.
        cyc(1'b1, 6'd7, 32'h3000_0007, 1'b1, 1'b0);
        chk("same_valid", 512'(out_valid), 512'(1'b1));
        chk("same_w7", 512'(out512[255:224]), 512'(32'h3000_0007));
        chk("same_w0", 512'(out512[31:0]), 512'(32'h2000_0000));

        // Write attempts while the block is held and during the handshake edge.
        cyc(1'b1, 6'h33, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("hold_err", 512'(err), 512'(1'b1));
        chk("hold_w3", 512'(out512[127:96]), 512'(32'h2000_0003));
        cyc(1'b1, 6'h02, 32'h0BAD_0BAD, 1'b0, 1'b1);
        chk("hsw_err", 512'(err), 512'(1'b1));
        chk("hsw_valid", 512'(out_valid), 512'(1'b0));
        chk("hsw_w2", 512'(out512[95:64]), 512'(32'h2000_0002));
        cyc(1'b1, 6'h33, 32'hCAFE_0003, 1'b0, 1'b0);
        chk("hi_idx_mask", 512'(word_mask), 512'(16'h0008));
        chk("hi_idx_w3", 512'(out512[127:96]), 512'(32'hCAFE_0003));
        chk("hi_idx_err", 512'(err), 512'(1'b0));

        // Reset while holding a block.
        for (int k = 0; k < 16; k++) cyc(1'b1, 6'(k), 32'h4000_0000 + 32'(k), 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_valid", 512'(out_valid), 512'(1'b1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 512'(out_valid), 512'(1'b0));
        chk("mid_rst_mask", 512'(word_mask), 512'(16'h0));
        chk("mid_rst_out", out512, 512'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic, checked each cycle by the compare process.
        repeat (3000) begin
            cyc($urandom_range(0, 9) < 7, 6'($urandom), $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_gather.md
Name: keccak_gather

Overview:
- Upstream packer for the Keccak path. Collects sixteen 32-bit words written by the CPU custom instruction (index from cust5_limm) into one 512-bit block.
- Presents the block to keccak_ctrl through a valid/ready handshake.
- Word k occupies bits [32k+31:32k], the same mapping the 512-to-32 word selector uses on the return path.

Parameters:
- NWORDS, 16, number of 32-bit words per block (fixed at 16 for 512-bit blocks; other values are not supported)
- IDXW, 4, width of the word index taken from num[IDXW-1:0]

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  word write strobe (one word per cycle when high)
- num  input  6  word index (=cust5_limm); only num[3:0] used, num[5:4] ignored
- in32  input  32  data word from CPU
- start  input  1  request to hand the assembled block to keccak_ctrl
- out512  output  512  assembled block to keccak_ctrl
- out_valid  output  1  out512 holds a complete block
- out_ready  input  1  keccak_ctrl accepts block
- word_mask  output  16  bit k set = word k written since last handoff
- busy  output  1  high in HOLD state
- err  output  1  one-cycle pulse on a rejected write or start

Behaviour:
- Reset (async assert, sync deassert handled externally) forces the following, irrespective of clk:
  - state=IDLE
  - out512=0, word_mask=0
  - out_valid=0, busy=0, err=0
- States: IDLE (mask==0), FILL (0<mask<all-ones or full, awaiting start), HOLD (block offered).
- Write, en=1 in IDLE/FILL:
  - out512[32*num[3:0] +: 32] <= in32 and word_mask[num[3:0]] <= 1 on the same edge.
  - Visible the next cycle.
  - IDLE->FILL on the first write.
  - Rewriting an already-set index overwrites the data; the mask is unchanged.
- Start in IDLE/FILL:
  - If word_mask==16'hFFFF: go to HOLD; out_valid=1 and busy=1 from the next cycle.
  - Otherwise: start is ignored and err pulses 1 cycle (see Optional Feature).
- Simultaneous en and start in the same cycle:
  - The write is applied first.
  - The start check uses the mask including that write, so the 16th word plus start goes to HOLD in one edge.
- HOLD:
  - out512 is frozen and out_valid stays high until out_ready=1 is sampled.
  - Handshake completes on a clk edge with out_valid&out_ready.
  - Next cycle: out_valid=0, busy=0, word_mask=0, state=IDLE.
  - out512 data is retained, not cleared.
- en in HOLD: write dropped, err pulses.
- start in HOLD: ignored, no err.
- out_ready while not HOLD: ignored.
- Latency: start to out_valid is 1 cycle; acceptance to the first new write being possible is 1 cycle (a write in the handshake cycle is rejected with err).
- Reset mid-HOLD: the block is discarded and all outputs return to reset values.
- err is registered, high for exactly 1 cycle per offending event.

Optional Feature:
- Macro KECCAK_GATHER_ZPAD_EN.
- Defined:
  - start with an incomplete mask is accepted (needs at least 1 word; an empty mask still gives err).
  - Words whose mask bit is 0 are driven as 32'h0 on out512 during HOLD.
  - Storage is not modified, so rewritten data is never mixed.
- Undefined: start with an incomplete mask gives err, as above.

Decomposition:
- Package keccak_pkg:
  - KECCAK_WORDS=16, KECCAK_BLKW=512, KECCAK_IDXW=4
  - state enum {ST_IDLE, ST_FILL, ST_HOLD}
  - MASK_FULL=16'hFFFF
- One natural sub-module, keccak_gather_wreg: one 32-bit word register with write-enable and mask bit; instantiated 16 times by generate.
- FSM and handshake remain in the top.

Test Plan:
- Reset then no stimulus -> out_valid=0, word_mask=0, out512=0, err=0.
- Write word k=32'h1000_0000+k for k=0..15, then start; hold out_ready=0 for 3 cycles, then assert -> out_valid high 4 cycles, out512[31:0]=32'h1000_0000, out512[511:480]=32'h1000_000F, mask=0 after the handshake.
- Write 15 words (skip idx 7), start -> err pulse 1 cycle, state unchanged, mask=16'hFF7F.
- Same as previous with KECCAK_GATHER_ZPAD_EN -> HOLD entered, out512[255:224]=0.
- 16th write and start in the same cycle -> out_valid next cycle with all words correct.
- en with num=6'h33 during HOLD -> err pulse, out512 unchanged; num[5:4]=2'b11 in FILL writes word 3.
- Assert rst_n=0 mid-HOLD -> out_valid drops immediately, mask=0.
